// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 2-flop synchroniser, tick generator, 3-sample majority vote,
// runtime parity/stop-bit selection, glitch and break detection, valid/ready holding register.
module uart_rx_os #(
    parameter int DataLength  = 8,
    parameter int Oversample  = 16,
    parameter int ClkDivWidth = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_rx,
    input  logic [ClkDivWidth-1:0] i_clk_div,
    input  logic [1:0]             i_parity_mode,
    input  logic                   i_two_stop,
    output logic [DataLength-1:0]  o_data,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic                   o_frame_err,
    output logic                   o_parity_err,
    output logic                   o_overrun,
    input  logic                   i_clr_overrun,
    output logic                   o_break,
    output logic                   o_busy
);

    localparam int SW = $clog2(Oversample);
    localparam int BW = $clog2(DataLength + 1);
    // The n-th tick of a bit is the one seen while s_cnt == n-1.
    localparam logic [SW-1:0] SMidM2 = SW'(Oversample / 2 - 2);
    localparam logic [SW-1:0] SMidM1 = SW'(Oversample / 2 - 1);
    localparam logic [SW-1:0] SMid   = SW'(Oversample / 2);
    localparam logic [SW-1:0] SLast  = SW'(Oversample - 1);
    localparam logic [BW-1:0] BLast  = BW'(DataLength - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRKWAIT
    } state_t;

    state_t                 r_state;
    logic                   r_sync1, r_sync2, r_rx_prev;
    logic [ClkDivWidth-1:0] r_tick_cnt;
    logic [SW-1:0]          r_s_cnt;
    logic [BW-1:0]          r_bit_cnt;
    logic [DataLength-1:0]  r_shift;
    logic                   r_smp0, r_smp1;
    logic                   r_par_en, r_odd, r_two;
    logic                   r_par_bit, r_par_err, r_ferr, r_stop2;

    logic w_rx_s, w_idle, w_fall, w_tick, w_bitclk, w_vote_now, w_bit_end;
    logic w_vote, w_break, w_ferr_final;

    assign w_rx_s       = r_sync2;
    assign w_idle       = (r_state == S_IDLE);
    assign w_fall       = r_rx_prev & ~r_sync2;
    assign w_tick       = (r_tick_cnt >= i_clk_div);
    assign w_bitclk     = w_tick && (r_state != S_IDLE) && (r_state != S_BRKWAIT);
    assign w_vote_now   = w_bitclk && (r_s_cnt == SMid);
    assign w_bit_end    = w_bitclk && (r_s_cnt == SLast);
    assign w_vote       = (r_smp0 & r_smp1) | (r_smp0 & w_rx_s) | (r_smp1 & w_rx_s);
    assign w_break      = (r_shift == '0) && !(r_par_en && r_par_bit) && !w_vote;
    assign w_ferr_final = r_ferr | ~w_vote;
    assign o_busy       = ~w_idle;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= i_rx;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
        end
    end

    // Restarting the divider on the start edge phase-aligns every later sample to it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tick_cnt <= '0;
        end else if ((w_idle && w_fall) || w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + ClkDivWidth'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_s_cnt      <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_smp0       <= 1'b1;
            r_smp1       <= 1'b1;
            r_par_en     <= 1'b0;
            r_odd        <= 1'b0;
            r_two        <= 1'b0;
            r_par_bit    <= 1'b0;
            r_par_err    <= 1'b0;
            r_ferr       <= 1'b0;
            r_stop2      <= 1'b0;
            o_data       <= '0;
            o_valid      <= 1'b0;
            o_frame_err  <= 1'b0;
            o_parity_err <= 1'b0;
            o_overrun    <= 1'b0;
            o_break      <= 1'b0;
        end else begin
            o_break <= 1'b0;
            if (o_valid && i_ready) o_valid <= 1'b0;
            if (i_clr_overrun) o_overrun <= 1'b0;
            if (w_bitclk) r_s_cnt <= (r_s_cnt == SLast) ? '0 : r_s_cnt + SW'(1);
            if (w_bitclk && r_s_cnt == SMidM2) r_smp0 <= w_rx_s;
            if (w_bitclk && r_s_cnt == SMidM1) r_smp1 <= w_rx_s;

            case (r_state)
                S_IDLE: begin
                    if (w_fall) begin
                        r_state   <= S_START;
                        r_s_cnt   <= '0;
                        r_bit_cnt <= '0;
                        r_par_en  <= i_parity_mode[1];
                        r_odd     <= i_parity_mode[0];
                        r_two     <= i_two_stop;
                        r_par_bit <= 1'b0;
                        r_par_err <= 1'b0;
                        r_ferr    <= 1'b0;
                        r_stop2   <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_vote_now && w_vote) r_state <= S_IDLE;
                    else if (w_bit_end) r_state <= S_DATA;
                end
                S_DATA: begin
                    if (w_vote_now) r_shift <= {w_vote, r_shift[DataLength-1:1]};
                    if (w_bit_end) begin
                        if (r_bit_cnt == BLast) begin
                            r_bit_cnt <= '0;
                            r_state   <= r_par_en ? S_PARITY : S_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BW'(1);
                        end
                    end
                end
                S_PARITY: begin
                    if (w_vote_now) begin
                        r_par_bit <= w_vote;
                        r_par_err <= (^r_shift) ^ w_vote ^ r_odd;
                    end
                    if (w_bit_end) r_state <= S_STOP;
                end
                S_STOP: begin
                    if (w_vote_now) begin
                        if (!r_stop2 && w_break) begin
                            o_break <= 1'b1;
                            r_state <= S_BRKWAIT;
                        end else if (r_two && !r_stop2) begin
                            r_ferr <= ~w_vote;
                        end else begin
                            // Completing at the final stop vote leaves half a bit to resync.
                            if (o_valid && !i_ready) begin
                                o_overrun <= 1'b1;
                            end else begin
                                o_data       <= r_shift;
                                o_frame_err  <= w_ferr_final;
                                o_parity_err <= r_par_en & r_par_err;
                                o_valid      <= 1'b1;
                            end
                            r_state <= S_IDLE;
                        end
                    end else if (w_bit_end) begin
                        r_stop2 <= 1'b1;
                    end
                end
                S_BRKWAIT: begin
                    if (w_rx_s) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: frame-level model builds expected words from the bits sent,
// a per-cycle monitor checks every load, hold stability and break pulses against it.
module tb_uart_rx_os;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx = 1'b1;
  logic [15:0]   clk_div = 16'd0;
  logic [1:0]    par_mode = 2'b00;
  logic          two_stop = 1'b0;
  logic          ready = 1'b1;
  logic          clr_ovr = 1'b0;
  logic [DW-1:0] o_data;
  logic          o_valid, o_frame_err, o_parity_err, o_overrun, o_break, o_busy;

  uart_rx_os #(.DataLength(DW), .Oversample(16), .ClkDivWidth(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx), .i_clk_div(clk_div),
    .i_parity_mode(par_mode), .i_two_stop(two_stop),
    .o_data(o_data), .o_valid(o_valid), .i_ready(ready),
    .o_frame_err(o_frame_err), .o_parity_err(o_parity_err),
    .o_overrun(o_overrun), .i_clr_overrun(clr_ovr),
    .o_break(o_break), .o_busy(o_busy)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  logic [DW+1:0] exp_q[$];  // {frame_err, parity_err, data}
  int cpb = 16;
  int exp_breaks = 0;
  int brk_cnt = 0;
  int held = 0;
  logic exp_ovr = 1'b0;
  int fall_cyc = 0;
  int load_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver tasks: entered and left at posedge+1
  task automatic drive_bit(input logic b);
    rx = b;
    repeat (cpb) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic s1, input logic s2);
    logic pen, odd, perr, ferr, brk;
    pen  = par_mode[1];
    odd  = par_mode[0];
    perr = pen & ((^d) ^ pbit ^ odd);
    ferr = !s1 | (two_stop & !s2);
    brk  = (d == 8'h00) && !(pen && pbit) && !s1;
    if (brk) exp_breaks++;
    else if (held != 0) exp_ovr = 1'b1;
    else begin
      exp_q.push_back({ferr, perr, d});
      if (!ready) held = 1;
    end
    fall_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (pen) drive_bit(pbit);
    drive_bit(s1);
    if (two_stop) drive_bit(s2);
    drive_bit(1'b1);
    drive_bit(1'b1);
  endtask

  // scoreboard monitor
  logic pv = 1'b0, pr = 1'b0, pb = 1'b0;
  logic [DW-1:0] hd = '0;
  logic [DW+1:0] e;
  always @(negedge clk) begin
    if (!rst_n) begin
      pv <= 1'b0;
      pr <= 1'b0;
      pb <= 1'b0;
    end else begin
      if (o_valid && (!pv || pr)) begin
        load_cyc <= cyc;
        check("load_expected", (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("word_data", o_data, e[DW-1:0]);
          check("word_parity_err", o_parity_err, e[DW]);
          check("word_frame_err", o_frame_err, e[DW+1]);
        end
        hd <= o_data;
      end else if (o_valid && pv && !pr) begin
        check("hold_stable", o_data, hd);
      end
      if (o_break) begin
        brk_cnt++;
        check("break_one_cycle", pb, 0);
      end
      pv <= o_valid;
      pr <= ready;
      pb <= o_break;
    end
  end

  initial begin
    #1_000_000;
    bad++;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  int lat, n;
  logic ferr_snap;
  int b0;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", o_data, 0);
    check("rst_valid", o_valid, 0);
    check("rst_frame_err", o_frame_err, 0);
    check("rst_parity_err", o_parity_err, 0);
    check("rst_overrun", o_overrun, 0);
    check("rst_break", o_break, 0);
    check("rst_busy", o_busy, 0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // 8N1 0xA5, latency from i_rx fall to o_valid
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
    check("a5_queue_empty", exp_q.size(), 0);
    check("a5_data_literal", o_data, 8'hA5);
    check("a5_errs_literal", {o_frame_err, o_parity_err}, 2'b00);
    check("a5_accepted", o_valid, 0);
    lat = load_cyc - fall_cyc;
    check("a5_latency_in_152pm4", (lat >= 148 && lat <= 156), 1);

    // parity
    par_mode = 2'b10;
    send_frame(8'h03, 1'b1, 1'b1, 1'b1);
    check("even_bad_perr_literal", o_parity_err, 1);
    check("even_bad_data_literal", o_data, 8'h03);
    send_frame(8'h03, 1'b0, 1'b1, 1'b1);
    check("even_good_perr_literal", o_parity_err, 0);
    par_mode = 2'b11;
    send_frame(8'h03, 1'b0, 1'b1, 1'b1);
    check("odd_bad_perr_literal", o_parity_err, 1);
    send_frame(8'hF0, 1'b1, 1'b1, 1'b1);
    par_mode = 2'b00;
    check("parity_queue_empty", exp_q.size(), 0);

    // start glitch
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx = 1'b1;
    @(negedge clk);
    check("glitch_busy_seen", o_busy, 1);
    n = 0;
    while (o_busy && n < 12) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("glitch_idle_within_12", o_busy, 0);
    repeat (cpb) @(posedge clk);
    #1;
    send_frame(8'h3C, 1'b0, 1'b1, 1'b1);
    check("after_glitch_data_literal", o_data, 8'h3C);
    check("glitch_queue_empty", exp_q.size(), 0);

    // overrun
    ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1, 1'b1);
    send_frame(8'h22, 1'b0, 1'b1, 1'b1);
    check("ovr_valid", o_valid, 1);
    check("ovr_data_literal", o_data, 8'h11);
    check("ovr_flag", o_overrun, exp_ovr);
    check("ovr_flag_literal", o_overrun, 1);
    ready = 1'b1;
    @(posedge clk);
    #1;
    ready = 1'b0;
    held = 0;
    @(posedge clk);
    #1;
    check("ovr_accept_drops_valid", o_valid, 0);
    check("ovr_sticky", o_overrun, 1);
    clr_ovr = 1'b1;
    @(posedge clk);
    #1;
    clr_ovr = 1'b0;
    exp_ovr = 1'b0;
    check("ovr_cleared", o_overrun, exp_ovr);
    ready = 1'b1;

    // break
    ferr_snap = o_frame_err;
    b0 = brk_cnt;
    rx = 1'b0;
    repeat (12 * cpb) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (2 * cpb) @(posedge clk);
    #1;
    check("break_count_literal", brk_cnt - b0, 1);
    check("break_ferr_unchanged", o_frame_err, ferr_snap);
    check("break_no_word", exp_q.size(), 0);
    exp_breaks++;
    send_frame(8'h00, 1'b0, 1'b0, 1'b1);
    check("break_count_model", brk_cnt, exp_breaks);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b1);
    check("after_break_data_literal", o_data, 8'h5A);

    // two stop bits, at 16 and 64 clocks per bit
    two_stop = 1'b1;
    send_frame(8'h81, 1'b0, 1'b1, 1'b0);
    check("two_stop_ferr_literal", o_frame_err, 1);
    check("two_stop_data_literal", o_data, 8'h81);
    send_frame(8'h81, 1'b0, 1'b1, 1'b1);
    check("two_stop_ok_ferr", o_frame_err, 0);
    clk_div = 16'd3;
    cpb = 64;
    send_frame(8'h81, 1'b0, 1'b1, 1'b0);
    check("div3_ferr_literal", o_frame_err, 1);
    check("div3_data_literal", o_data, 8'h81);
    two_stop = 1'b0;
    send_frame(8'hC6, 1'b0, 1'b1, 1'b1);
    clk_div = 16'd0;
    cpb = 16;

    // reset mid-frame
    rx = 1'b0;
    repeat (3 * cpb) @(posedge clk);
    #1;
    rst_n = 1'b0;
    rx = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_busy", o_busy, 0);
    check("midrst_valid", o_valid, 0);
    check("midrst_data", o_data, 0);
    rst_n = 1'b1;
    repeat (2 * cpb) @(posedge clk);
    #1;
    check("midrst_still_idle", o_busy, 0);
    send_frame(8'h96, 1'b0, 1'b1, 1'b1);
    check("midrst_recover_literal", o_data, 8'h96);

    check("final_queue_empty", exp_q.size(), 0);
    check("final_overrun", o_overrun, exp_ovr);
    check("final_breaks", brk_cnt, exp_breaks);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
Next-generation UART receiver with an integrated oversampling tick generator, 2-flop input synchroniser and 3-sample majority vote. Runtime-selectable parity (none/even/odd) and 1 or 2 stop bits. Start-glitch rejection and break detection. Delivers each word through a valid/ready holding register with overrun detection. Sits between the pad and the RX FIFO, replacing the fixed-strobe receiver.

Parameters:
DataLength, 8, data bits per frame (5..9), LSB first
Oversample, 16, ticks per bit (even, >=4)
ClkDivWidth, 16, width of i_clk_div

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_rx  in  1  serial line, asynchronous, idle high
i_clk_div  in  ClkDivWidth  clocks per tick minus 1 (0 = tick every clock)
i_parity_mode  in  2  00/01 none, 10 even, 11 odd
i_two_stop  in  1  1 = two stop bits
o_data  out  DataLength  received word
o_valid  out  1  o_data holds an unaccepted word
i_ready  in  1  consumer accepts when o_valid && i_ready
o_frame_err  out  1  stop bit(s) sampled 0, qualifies o_data
o_parity_err  out  1  parity mismatch, qualifies o_data
o_overrun  out  1  sticky: frame completed while o_valid && !i_ready
i_clr_overrun  in  1  clears o_overrun
o_break  out  1  one-cycle pulse on break detection
o_busy  out  1  FSM not in IDLE

Behaviour:
- Reset: synchroniser flops 1; FSM IDLE; all counters 0. o_data 0; o_valid, o_frame_err, o_parity_err, o_overrun, o_break, o_busy all 0. Reset mid-frame aborts it; no partial word is output.
- rx_s = i_rx after 2 flops. Falling edge = rx_s 0 while its previous value was 1.
- Tick counter: runs 0..i_clk_div; tick on terminal count. Cleared on falling edge in IDLE, which phase-aligns bit timing.
- Sample counter s_cnt (clog2(Oversample) bits): increments per tick, wraps Oversample-1 -> 0; each wrap ends a bit. Samples taken at ticks mid-1, mid, mid+1 (mid = Oversample/2). Vote = majority of the three, valid at tick mid+1.
- i_parity_mode and i_two_stop are latched on the falling edge in IDLE. Changes mid-frame have no effect.
- FSM states:
  - IDLE: on falling edge -> START.
  - START: vote 1 -> IDLE (glitch, no output). Vote 0 -> DATA at end of bit.
  - DATA: vote shifted in LSB first; bit counter (clog2(DataLength+1) bits). After the DataLength-th bit ends -> PARITY if parity enabled, else STOP.
  - PARITY: store voted bit. Error when (^data ^ bit) != 0 for even, or == 0 for odd. End of bit -> STOP.
  - STOP: vote each stop bit. With i_two_stop, wait to the end of the first stop bit, then vote the second. Frame completes at the vote of the final stop bit, not at its end, allowing back-to-back resync.
- Frame completion, normal case (not break):
  - If o_valid && !i_ready: o_overrun <= 1; new word and flags discarded; holding register unchanged.
  - Otherwise: load o_data, o_frame_err (any stop bit 0), o_parity_err (0 when parity none); o_valid <= 1; next state IDLE.
- Break: data all 0, parity bit 0 (if enabled) and first stop vote 0. o_break pulses 1 cycle, nothing loaded, o_frame_err unchanged. Next state BRKWAIT; leave to IDLE when rx_s is 1. No falling edge is accepted in BRKWAIT.
- Handshake: o_valid && i_ready clears o_valid next cycle. Accept and completion in the same cycle: new word loaded, o_valid stays 1, no overrun.
- o_overrun: sticky. i_clr_overrun clears it; a simultaneous set takes priority.
- o_busy = (state != IDLE).

Test Plan:
- Oversample=16, i_clk_div=0, 8N1, byte 0xA5 at 16 clk/bit -> one o_valid with o_data=0xA5, errors 0. Asserted 152±4 clocks after the i_rx falling edge.
- Even parity, 0x03 sent with parity bit 1 -> o_data=0x03, o_parity_err=1. Resend with parity 0 -> o_parity_err=0.
- i_rx low for 4 clocks then high -> no o_valid, o_busy back to 0 within 12 clocks. A following 0x3C is received correctly.
- i_ready=0; frames 0x11 then 0x22 -> o_data=0x11, o_overrun=1. i_ready pulse drops o_valid; i_clr_overrun -> o_overrun=0.
- i_rx low for 12 bit times, then high -> exactly one o_break pulse, no o_valid. Next frame 0x5A is received correctly.
- i_two_stop=1, 0x81 with second stop bit 0 -> o_data=0x81, o_frame_err=1. i_clk_div=3 with 64 clk/bit gives identical results.
